branch_resolve_ctrl: RTL and testbench

//  ID-stage branch sequencer. Decodes beq/bne/blez/bgtz/bgez/bltz and stalls ID until the

---
 rtl/branch_resolve_ctrl.sv | 162 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl
// Purpose  : ID-stage branch sequencer. Decodes beq/bne/blez/bgtz/bgez/bltz,
//            holds ID until the branch operands are final, evaluates the
//            condition, computes the target and issues a one-cycle registered
//            PC redirect with IF/ID and ID/EX flushes. Keeps saturating
//            branch statistics.
// Ports    : clk, rst_n (sync, active low)
//            id_valid, id_opcode, id_rt_field, id_imm, id_pc_plus4 - ID instr
//            rs_val, rt_val, rs_ready, rt_ready - forwarded operands
//            ext_flush      - later-stage flush, overrides everything here
//            stall_id       - hold PC and IF/ID (combinational)
//            redirect_valid, redirect_pc - PC redirect
//            flush_if_id, flush_id_ex   - wrong-path bubbles
//            branch_cnt, taken_cnt, stall_cnt - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rt_field,
  input  logic [15:0]      id_imm,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             ext_flush,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [5:0] c_op_regimm = 6'h01;
  localparam logic [5:0] c_op_beq    = 6'h04;
  localparam logic [5:0] c_op_bne    = 6'h05;
  localparam logic [5:0] c_op_blez   = 6'h06;
  localparam logic [5:0] c_op_bgtz   = 6'h07;
  localparam logic [4:0] c_rt_bltz   = 5'b00000;
  localparam logic [4:0] c_rt_bgez   = 5'b00001;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic        w_is_beq, w_is_bne, w_is_blez, w_is_bgtz, w_is_bgez, w_is_bltz;
  logic        w_is_branch, w_ops_ready, w_taken, w_br;
  logic        w_rs_zero, w_rs_neg;
  logic [31:0] w_target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_cnt_one;
  endfunction

  // Decode and condition evaluation
  always_comb begin
    w_is_beq    = (id_opcode == c_op_beq);
    w_is_bne    = (id_opcode == c_op_bne);
    w_is_blez   = (id_opcode == c_op_blez);
    w_is_bgtz   = (id_opcode == c_op_bgtz);
    w_is_bgez   = (id_opcode == c_op_regimm) && (id_rt_field == c_rt_bgez);
    w_is_bltz   = (id_opcode == c_op_regimm) && (id_rt_field == c_rt_bltz);
    w_is_branch = w_is_beq | w_is_bne | w_is_blez | w_is_bgtz | w_is_bgez | w_is_bltz;

    // Only the two-register compares depend on rt
    w_ops_ready = (w_is_beq | w_is_bne) ? (rs_ready & rt_ready) : rs_ready;

    w_rs_zero = (rs_val == 32'd0);
    w_rs_neg  = rs_val[31];

    w_taken = (w_is_beq  &  (rs_val == rt_val))
            | (w_is_bne  &  (rs_val != rt_val))
            | (w_is_blez &  (w_rs_neg | w_rs_zero))
            | (w_is_bgtz & ~(w_rs_neg | w_rs_zero))
            | (w_is_bgez & ~w_rs_neg)
            | (w_is_bltz &  w_rs_neg);

    w_target = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};

    // The instruction in ID during REDIRECT is wrong-path, so it never counts
    w_br = id_valid & w_is_branch & (state_q != S_REDIRECT) & ~ext_flush;
  end

  // Next state, counters and outputs
  always_comb begin
    state_d       = S_IDLE;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    stall_cnt_d   = stall_cnt_q;

    // Outputs are forced low while reset is asserted, even mid-REDIRECT
    stall_id       = rst_n & w_br & ~w_ops_ready;
    redirect_valid = rst_n & (state_q == S_REDIRECT) & ~ext_flush;
    flush_if_id    = redirect_valid;
    flush_id_ex    = redirect_valid;

    if (stall_id) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (w_br) begin
          if (!w_ops_ready) begin
            state_d = S_WAIT;
          end else begin
            branch_cnt_d = sat_inc(branch_cnt_q);
            if (w_taken) begin
              taken_cnt_d   = sat_inc(taken_cnt_q);
              redirect_pc_d = w_target;
              state_d       = S_REDIRECT;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      redirect_pc_q <= 32'd0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign taken_cnt   = taken_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_ctrl
// Purpose  : Directed self-checking bench for branch_resolve_ctrl. A second
//            instance with 2-bit counters shares the stimulus to exercise
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rt_field;
  logic [15:0] id_imm;
  logic [31:0] id_pc_plus4;
  logic [31:0] rs_val, rt_val;
  logic        rs_ready, rt_ready, ext_flush;

  logic        stall_id, redirect_valid, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, taken_cnt, stall_cnt;

  logic        s_stall_id, s_redirect_valid, s_flush_if_id, s_flush_id_ex;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_branch_cnt, s_taken_cnt, s_stall_cnt;

  int tests;
  int fails;
  int exp_bc, exp_tc, exp_sc;

  branch_resolve_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rt_field(id_rt_field), .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
    .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .ext_flush(ext_flush), .stall_id(stall_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  branch_resolve_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rt_field(id_rt_field), .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
    .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .ext_flush(ext_flush), .stall_id(s_stall_id), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle; returns 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid    = 1'b0;
    id_opcode   = 6'h00;
    id_rt_field = 5'd0;
    id_imm      = 16'd0;
    id_pc_plus4 = 32'd0;
    rs_val      = 32'd0;
    rt_val      = 32'd0;
    rs_ready    = 1'b1;
    rt_ready    = 1'b1;
    ext_flush   = 1'b0;
  endtask

  task automatic drive_br(input logic [5:0] op, input logic [4:0] rtf,
                          input logic [31:0] pc4, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rt);
    id_valid    = 1'b1;
    id_opcode   = op;
    id_rt_field = rtf;
    id_pc_plus4 = pc4;
    id_imm      = imm;
    rs_val      = rs;
    rt_val      = rt;
    rs_ready    = 1'b1;
    rt_ready    = 1'b1;
  endtask

  task automatic check_counters(input string name);
    tests++;
    if (branch_cnt !== exp_bc[15:0] || taken_cnt !== exp_tc[15:0] || stall_cnt !== exp_sc[15:0]) begin
      fails++;
      $display("FAIL %s: counters b/t/s got %0d/%0d/%0d, want %0d/%0d/%0d", name,
               branch_cnt, taken_cnt, stall_cnt, exp_bc, exp_tc, exp_sc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if ({stall_id, redirect_valid, flush_if_id, flush_id_ex} !== 4'b0000 || redirect_pc !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ctl=%b pc=%h, want ctl=0000 pc=0",
               {stall_id, redirect_valid, flush_if_id, flush_id_ex}, redirect_pc);
    end
    exp_bc = 0; exp_tc = 0; exp_sc = 0;
    check_counters("reset_counters");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_taken();
    drive_br(6'h04, 5'd0, 32'h100, 16'h0004, 32'd5, 32'd5);
    #1;
    tests++;
    if (stall_id !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL beq_resolve_cycle: stall=%b redir=%b, want 0 0", stall_id, redirect_valid);
    end
    tick();
    exp_bc++; exp_tc++;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h110 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      fails++;
      $display("FAIL beq_redirect: redir=%b pc=%h fl=%b%b, want 1 00000110 11",
               redirect_valid, redirect_pc, flush_if_id, flush_id_ex);
    end
    check_counters("beq_counts");
    // Same branch still presented during REDIRECT: must be ignored
    tick();
    id_valid = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0) begin
      fails++;
      $display("FAIL beq_redirect_one_cycle: redir=%b fl=%b, want 0 0", redirect_valid, flush_if_id);
    end
    check_counters("beq_redirect_ignored");
  endtask

  task automatic test_cond_variants();
    // bne equal -> not taken
    drive_br(6'h05, 5'd0, 32'h180, 16'h0008, 32'd7, 32'd7);
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++;
      $display("FAIL bne_stall: got %b want 0", stall_id);
    end
    tick();
    exp_bc++;
    tests++;
    if (redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL bne_not_taken: redir=%b want 0", redirect_valid);
    end
    check_counters("bne_counts");
    // bgtz 0 -> not taken
    drive_br(6'h07, 5'd0, 32'h1C0, 16'h0008, 32'd0, 32'd0);
    tick();
    exp_bc++;
    tests++;
    if (redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL bgtz_zero: redir=%b want 0", redirect_valid);
    end
    check_counters("bgtz_counts");
    // blez 0 -> taken, target 0x200 + 0x40
    drive_br(6'h06, 5'd0, 32'h200, 16'h0010, 32'd0, 32'd0);
    tick();
    exp_bc++; exp_tc++;
    id_valid = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin
      fails++;
      $display("FAIL blez_zero: redir=%b pc=%h, want 1 00000240", redirect_valid, redirect_pc);
    end
    check_counters("blez_counts");
    tick();
  endtask

  task automatic test_stall_bltz();
    drive_br(6'h01, 5'b00000, 32'h300, 16'h0002, 32'd0, 32'd0);
    rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (stall_id !== 1'b1) begin
        fails++;
        $display("FAIL bltz_stall_%0d: stall=%b want 1", i, stall_id);
      end
      tick();
      exp_sc++;
    end
    rs_ready = 1'b1;
    rs_val   = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++;
      $display("FAIL bltz_release: stall=%b want 0", stall_id);
    end
    tick();
    exp_bc++; exp_tc++;
    id_valid = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h308) begin
      fails++;
      $display("FAIL bltz_redirect: redir=%b pc=%h, want 1 00000308", redirect_valid, redirect_pc);
    end
    check_counters("bltz_counts");
    tick();
  endtask

  task automatic test_target_wrap();
    drive_br(6'h01, 5'b00001, 32'h8, 16'hFFFF, 32'd0, 32'd0);
    tick();
    id_valid = 1'b0;
    exp_bc++; exp_tc++;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4) begin
      fails++;
      $display("FAIL bgez_back: redir=%b pc=%h, want 1 00000004", redirect_valid, redirect_pc);
    end
    tick();
    drive_br(6'h01, 5'b00001, 32'hFFFF_FFFC, 16'h0001, 32'd1, 32'd0);
    tick();
    id_valid = 1'b0;
    exp_bc++; exp_tc++;
    #1;
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL bgez_wrap: redir=%b pc=%h, want 1 00000000", redirect_valid, redirect_pc);
    end
    check_counters("bgez_counts");
    tick();
  endtask

  task automatic test_ext_flush();
    // Flush while waiting on rt
    drive_br(6'h04, 5'd0, 32'h400, 16'h0001, 32'd3, 32'd3);
    rt_ready = 1'b0;
    tick();
    exp_sc++;
    ext_flush = 1'b1;
    #1;
    tests++;
    if (stall_id !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_wait: stall=%b redir=%b, want 0 0", stall_id, redirect_valid);
    end
    tick();
    ext_flush = 1'b0;
    id_valid  = 1'b0;
    check_counters("flush_wait_counts");
    tick();
    // Flush in the REDIRECT cycle
    drive_br(6'h04, 5'd0, 32'h500, 16'h0001, 32'd3, 32'd3);
    tick();
    exp_bc++; exp_tc++;
    id_valid  = 1'b0;
    ext_flush = 1'b1;
    #1;
    tests++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
      fails++;
      $display("FAIL flush_redirect: redir=%b fl=%b%b, want 0 00", redirect_valid, flush_if_id, flush_id_ex);
    end
    tick();
    ext_flush = 1'b0;
    #1;
    tests++;
    if (redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_redirect_after: redir=%b want 0", redirect_valid);
    end
    check_counters("flush_redirect_counts");
    // Reset while in REDIRECT
    drive_br(6'h04, 5'd0, 32'h600, 16'h0001, 32'd3, 32'd3);
    tick();
    id_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests++;
    if ({stall_id, redirect_valid, flush_if_id, flush_id_ex} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_in_redirect: ctl=%b want 0000", {stall_id, redirect_valid, flush_if_id, flush_id_ex});
    end
    tick();
    exp_bc = 0; exp_tc = 0; exp_sc = 0;
    tests++;
    if ({stall_id, redirect_valid, flush_if_id, flush_id_ex} !== 4'b0000 || redirect_pc !== 32'd0) begin
      fails++;
      $display("FAIL reset_after_redirect: ctl=%b pc=%h, want 0000 0",
               {stall_id, redirect_valid, flush_if_id, flush_id_ex}, redirect_pc);
    end
    check_counters("reset_after_redirect_counts");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive_br(6'h04, 5'd0, 32'h700, 16'h0001, 32'd9, 32'd9);
      tick();
      id_valid = 1'b0;
      tick();
      exp_bc++; exp_tc++;
    end
    tests++;
    if (s_branch_cnt !== 2'd3 || s_taken_cnt !== 2'd3) begin
      fails++;
      $display("FAIL sat_counters: got %0d/%0d want 3/3", s_branch_cnt, s_taken_cnt);
    end
    check_counters("sat_wide_counts");
    // Unknown REGIMM sub-op: not a branch
    drive_br(6'h01, 5'b00010, 32'h800, 16'h0001, 32'd0, 32'd0);
    rs_ready = 1'b0;
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++;
      $display("FAIL regimm_other_stall: stall=%b want 0", stall_id);
    end
    tick();
    tests++;
    if (redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL regimm_other_redirect: redir=%b want 0", redirect_valid);
    end
    check_counters("regimm_other_counts");
    idle_inputs();
    tick();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    exp_bc = 0; exp_tc = 0; exp_sc = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_beq_taken();
    test_cond_variants();
    test_stall_bltz();
    test_target_wrap();
    test_ext_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
